// File: rtl/fht_pkg.sv
// -----------------------------------------------------------------------------
// fht_pkg
// Shared definitions for the FHT butterfly feeder:
//   - fsm_state_t   : sequencer states (IDLE, RUN, DRAIN, FIN)
//   - RD_LAT        : sample RAM / coefficient ROM read latency (cycles)
//   - BUT_LAT       : butterfly pipeline depth (cycles)
//   - WR_DLY        : issue-to-write-back distance (RD_LAT + BUT_LAT)
//   - DRAIN_CYC     : idle cycles between stages so the last write lands
//   - stage_bits()  : width needed to hold a stage number 0..LOG2N
// -----------------------------------------------------------------------------
package fht_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } fsm_state_t;

   localparam int RD_LAT    = 1;
   localparam int BUT_LAT   = 2;
   localparam int WR_DLY    = RD_LAT + BUT_LAT;
   // The last butterfly of a stage writes WR_DLY cycles after it issues,
   // so the stage must idle that long before the banks can swap.
   localparam int DRAIN_CYC = 3;

   function automatic int stage_bits(input int log2n);
      return $clog2(log2n + 1);
   endfunction

endpackage

// File: rtl/fht_addr_gen.sv
// -----------------------------------------------------------------------------
// fht_addr_gen
// Purely combinational index generator for one radix-2 FHT butterfly.
// Ports:
//   s    in  stage number, 1..LOG2N
//   b    in  butterfly number within the stage, 0..N/2-1
//   idx0 out index of x0 / y0
//   idx1 out index of x1 / y1 (idx0 + half)
//   idx2 out index of the mirrored partner x2
//   w    out rotation coefficient ROM address
// -----------------------------------------------------------------------------
module fht_addr_gen
   import fht_pkg::*;
#(
   parameter int LOG2N  = 8,
   parameter int A_BIT  = LOG2N,
   parameter int W_ABIT = LOG2N - 1,
   localparam int SW    = stage_bits(LOG2N),
   localparam int BW    = LOG2N - 1
) (
   input  logic [SW-1:0]     s,
   input  logic [BW-1:0]     b,
   output logic [A_BIT-1:0]  idx0,
   output logic [A_BIT-1:0]  idx1,
   output logic [A_BIT-1:0]  idx2,
   output logic [W_ABIT-1:0] w
);

   logic [A_BIT-1:0]  b_ext;
   logic [A_BIT-1:0]  half;
   logic [A_BIT-1:0]  mask;
   logic [A_BIT-1:0]  k;
   logic [A_BIT-1:0]  base;
   logic [W_ABIT-1:0] k_w;
   logic [SW-1:0]     w_shift;

   assign b_ext = A_BIT'(b);
   assign half  = A_BIT'(1) << (s - SW'(1));
   assign mask  = half - A_BIT'(1);

   // half is a power of two, so b mod half and (b >> (s-1)) * 2 * half
   // reduce to masking: the group bits of b shifted up by one place.
   assign k     = b_ext & mask;
   assign base  = (b_ext & ~mask) << 1;

   assign idx0  = base | k;
   assign idx1  = idx0 + half;
   assign idx2  = base + half + ((half - k) & mask);

   // k < half = 2^(s-1) <= 2^(LOG2N-1), so it always fits the ROM address.
   assign k_w     = W_ABIT'(k);
   assign w_shift = SW'(LOG2N) - s;
   assign w       = k_w << w_shift;

endmodule

// File: rtl/fht_but_feeder.sv
// -----------------------------------------------------------------------------
// fht_but_feeder
// Sequences the fht_but butterfly through a full N-point radix-2 FHT,
// one butterfly per cycle, reading one ping-pong bank and writing the other.
// Ports:
//   iCLK, iRESET        clock, asynchronous active-high reset
//   iSTART              start pulse, ignored unless idle
//   oRD_EN_12           oRD_ADDR_1/2 and oW_ADDR valid (issue cycle t)
//   oRD_ADDR_1/2        sample addresses for iX_1 / iX_2
//   oW_ADDR             coefficient ROM address
//   oRD_EN_0, oRD_ADDR_0  sample address for iX_0 (cycle t+1)
//   oWR_EN              write-back strobe (cycle t+3)
//   oWR_ADDR_0/1        destinations of oY_0 / oY_1
//   oBANK               bank being read; writes go to ~oBANK
//   oBUSY               high in RUN and DRAIN
//   oDONE               one-cycle completion pulse
// -----------------------------------------------------------------------------
module fht_but_feeder
   import fht_pkg::*;
#(
   parameter int LOG2N  = 8,
   parameter int A_BIT  = LOG2N,
   parameter int W_ABIT = LOG2N - 1
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              iSTART,
   output logic              oRD_EN_12,
   output logic [A_BIT-1:0]  oRD_ADDR_1,
   output logic [A_BIT-1:0]  oRD_ADDR_2,
   output logic [W_ABIT-1:0] oW_ADDR,
   output logic              oRD_EN_0,
   output logic [A_BIT-1:0]  oRD_ADDR_0,
   output logic              oWR_EN,
   output logic [A_BIT-1:0]  oWR_ADDR_0,
   output logic [A_BIT-1:0]  oWR_ADDR_1,
   output logic              oBANK,
   output logic              oBUSY,
   output logic              oDONE
);

   localparam int SW = stage_bits(LOG2N);
   localparam int BW = LOG2N - 1;
   localparam int DW = $clog2(DRAIN_CYC);

   fsm_state_t       state_reg, state_next;
   logic [SW-1:0]    s_reg, s_next;
   logic [BW-1:0]    b_reg, b_next;
   logic [DW-1:0]    dcnt_reg, dcnt_next;
   logic             bank_reg, bank_next;

   logic             issue_next;
   logic [A_BIT-1:0] gen_idx0, gen_idx1, gen_idx2;
   logic [W_ABIT-1:0] gen_w;

   logic [A_BIT-1:0]  rd_addr_2_reg;
   logic [W_ABIT-1:0] w_addr_reg;
   logic              busy_reg;
   logic              done_reg;

   // Index pipe: element 0 is the issue cycle, element i is i cycles later.
   logic              en_pipe_reg   [0:WR_DLY];
   logic [A_BIT-1:0]  idx0_pipe_reg [0:WR_DLY];
   logic [A_BIT-1:0]  idx1_pipe_reg [0:WR_DLY];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_reg <= ST_IDLE;
         s_reg     <= '0;
         b_reg     <= '0;
         dcnt_reg  <= '0;
         bank_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         b_reg     <= b_next;
         dcnt_reg  <= dcnt_next;
         bank_reg  <= bank_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      b_next     = b_reg;
      dcnt_next  = dcnt_reg;
      bank_next  = bank_reg;
      case (state_reg)
         ST_IDLE: begin
            if (iSTART) begin
               state_next = ST_RUN;
               s_next     = SW'(1);
               b_next     = '0;
               bank_next  = 1'b0;
            end
         end
         ST_RUN: begin
            if (b_reg == '1) begin
               state_next = ST_DRAIN;
               dcnt_next  = '0;
            end else begin
               b_next = b_reg + BW'(1);
            end
         end
         ST_DRAIN: begin
            if (dcnt_reg == DW'(DRAIN_CYC - 1)) begin
               bank_next = ~bank_reg;
               if (s_reg == SW'(LOG2N)) begin
                  state_next = ST_FIN;
               end else begin
                  state_next = ST_RUN;
                  s_next     = s_reg + SW'(1);
                  b_next     = '0;
               end
            end else begin
               dcnt_next = dcnt_reg + DW'(1);
            end
         end
         ST_FIN: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered, so indices are generated from the butterfly
   // that will be on the outputs in the coming cycle.
   assign issue_next = (state_next == ST_RUN);

   fht_addr_gen #(
      .LOG2N  (LOG2N),
      .A_BIT  (A_BIT),
      .W_ABIT (W_ABIT)
   ) u_addr_gen (
      .s    (s_next),
      .b    (b_next),
      .idx0 (gen_idx0),
      .idx1 (gen_idx1),
      .idx2 (gen_idx2),
      .w    (gen_w)
   );

   // ---------------------------------------------------- issue-cycle regs
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         en_pipe_reg[0]   <= 1'b0;
         idx0_pipe_reg[0] <= '0;
         idx1_pipe_reg[0] <= '0;
         rd_addr_2_reg    <= '0;
         w_addr_reg       <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
      end else begin
         en_pipe_reg[0]   <= issue_next;
         idx0_pipe_reg[0] <= issue_next ? gen_idx0 : '0;
         idx1_pipe_reg[0] <= issue_next ? gen_idx1 : '0;
         rd_addr_2_reg    <= issue_next ? gen_idx2 : '0;
         w_addr_reg       <= issue_next ? gen_w    : '0;
         busy_reg         <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
         done_reg         <= (state_next == ST_FIN);
      end
   end

   // ------------------------------------------------------- delay pipe
   generate
      for (genvar gi = 1; gi <= WR_DLY; gi++) begin : g_pipe
         always_ff @(posedge iCLK or posedge iRESET) begin
            if (iRESET) begin
               en_pipe_reg[gi]   <= 1'b0;
               idx0_pipe_reg[gi] <= '0;
               idx1_pipe_reg[gi] <= '0;
            end else begin
               en_pipe_reg[gi]   <= en_pipe_reg[gi-1];
               idx0_pipe_reg[gi] <= idx0_pipe_reg[gi-1];
               idx1_pipe_reg[gi] <= idx1_pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign oRD_EN_12  = en_pipe_reg[0];
   assign oRD_ADDR_1 = idx1_pipe_reg[0];
   assign oRD_ADDR_2 = rd_addr_2_reg;
   assign oW_ADDR    = w_addr_reg;
   assign oRD_EN_0   = en_pipe_reg[RD_LAT];
   assign oRD_ADDR_0 = idx0_pipe_reg[RD_LAT];
   assign oWR_EN     = en_pipe_reg[WR_DLY];
   assign oWR_ADDR_0 = idx0_pipe_reg[WR_DLY];
   assign oWR_ADDR_1 = idx1_pipe_reg[WR_DLY];
   assign oBANK      = bank_reg;
   assign oBUSY      = busy_reg;
   assign oDONE      = done_reg;

endmodule

// File: tb/tb_fht_but_feeder.sv
// -----------------------------------------------------------------------------
// tb_fht_but_feeder
// Self-checking bench for fht_but_feeder with LOG2N=3 (N=8). A cycle-level
// model derives every expected output from the run start cycle and the
// stage/butterfly index formulas; literal expectations pin key cycles.
// -----------------------------------------------------------------------------
module tb_fht_but_feeder;

   localparam int L  = 3;
   localparam int N  = 8;
   localparam int H  = N / 2;
   localparam int P  = H + 3;      // cycles per stage: issues + drain
   localparam int AB = 3;
   localparam int WB = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          rd_en_12, rd_en_0, wr_en, bank, busy, done;
   logic [AB-1:0] rd_addr_1, rd_addr_2, rd_addr_0, wr_addr_0, wr_addr_1;
   logic [WB-1:0] w_addr;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int c0 = 0;
   bit run_valid = 1'b0;
   int prev_bank = 0;

   always #5 clk = ~clk;

   fht_but_feeder #(.LOG2N(L), .A_BIT(AB), .W_ABIT(WB)) dut (
      .iCLK       (clk),
      .iRESET     (rst),
      .iSTART     (start),
      .oRD_EN_12  (rd_en_12),
      .oRD_ADDR_1 (rd_addr_1),
      .oRD_ADDR_2 (rd_addr_2),
      .oW_ADDR    (w_addr),
      .oRD_EN_0   (rd_en_0),
      .oRD_ADDR_0 (rd_addr_0),
      .oWR_EN     (wr_en),
      .oWR_ADDR_0 (wr_addr_0),
      .oWR_ADDR_1 (wr_addr_1),
      .oBANK      (bank),
      .oBUSY      (busy),
      .oDONE      (done)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // ------------------------------------------------------------ model
   function automatic bit m_busy(input int x);
      int r;
      r = x - c0;
      return run_valid && (r >= 1) && (r <= L * P);
   endfunction

   function automatic bit m_fin(input int x);
      return run_valid && (x - c0 == L * P + 1);
   endfunction

   function automatic int m_bank(input int x);
      int r;
      r = x - c0;
      if (!run_valid) return 0;
      if (r < 1) return prev_bank;
      if (r <= L * P) return ((r - 1) / P) % 2;
      return L % 2;
   endfunction

   task automatic m_issue(input int x, output bit v, output int i0, output int i1,
                          output int i2, output int w);
      int r, st, pos, half, k, g;
      v = 1'b0; i0 = 0; i1 = 0; i2 = 0; w = 0;
      r = x - c0;
      if (run_valid && r >= 1 && r <= L * P) begin
         st  = (r - 1) / P + 1;
         pos = (r - 1) % P;
         if (pos < H) begin
            v    = 1'b1;
            half = 1 << (st - 1);
            k    = pos % half;
            g    = pos / half;
            i0   = g * 2 * half + k;
            i1   = i0 + half;
            i2   = g * 2 * half + half + ((half - k) % half);
            w    = k << (L - st);
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         run_valid <= 1'b0;
      end else if (start && !m_busy(cyc) && !m_fin(cyc)) begin
         prev_bank <= m_bank(cyc);
         c0        <= cyc;
         run_valid <= 1'b1;
      end
      cyc <= cyc + 1;
   end

   // ---------------------------------------------------------- compare
   always @(negedge clk) begin
      bit v;
      int i0, i1, i2, w;
      if (rst) begin
         chk("rst_rd_en_12", rd_en_12, 0);
         chk("rst_rd_en_0", rd_en_0, 0);
         chk("rst_wr_en", wr_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_bank", bank, 0);
         chk("rst_addrs", int'(rd_addr_1) + rd_addr_2 + w_addr + rd_addr_0
             + wr_addr_0 + wr_addr_1, 0);
      end else begin
         m_issue(cyc, v, i0, i1, i2, w);
         chk("rd_en_12", rd_en_12, v);
         if (v) begin
            chk("rd_addr_1", rd_addr_1, i1);
            chk("rd_addr_2", rd_addr_2, i2);
            chk("w_addr", w_addr, w);
         end
         m_issue(cyc - 1, v, i0, i1, i2, w);
         chk("rd_en_0", rd_en_0, v);
         if (v) chk("rd_addr_0", rd_addr_0, i0);
         m_issue(cyc - 3, v, i0, i1, i2, w);
         chk("wr_en", wr_en, v);
         if (v) begin
            chk("wr_addr_0", wr_addr_0, i0);
            chk("wr_addr_1", wr_addr_1, i1);
         end
         chk("busy", busy, m_busy(cyc));
         chk("done", done, m_fin(cyc));
         chk("bank", bank, m_bank(cyc));
      end
   end

   // --------------------------------------------------------- stimulus
   task automatic goto_cycle(input int target);
      int n;
      n = 0;
      while (cyc != target && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (cyc != target) chk("goto_timeout", cyc, target);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int base;
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Run A: aborted by reset in cycle 9 (stage 2, b=1)
      base = cyc;
      $display("txn: start run A at cycle %0d", base);
      pulse_start();
      goto_cycle(base + 8);
      @(posedge clk);
      #1;
      chk("lit_preRst_addr1", rd_addr_1, 3);
      chk("lit_preRst_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      $display("txn: async reset mid-run at cycle %0d", cyc);
      chk("lit_async_busy", busy, 0);
      chk("lit_async_rd_en_12", rd_en_12, 0);
      chk("lit_async_addr1", rd_addr_1, 0);
      chk("lit_async_bank", bank, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("lit_idle_busy", busy, 0);

      // Run B: full clean run, second start at cycle 10 ignored
      base = cyc;
      $display("txn: start run B at cycle %0d", base);
      pulse_start();
      goto_cycle(base + 1);
      chk("lit_s1b0_addr1", rd_addr_1, 1);
      chk("lit_s1b0_addr2", rd_addr_2, 1);
      chk("lit_s1b0_w", w_addr, 0);
      goto_cycle(base + 2);
      chk("lit_s1b0_addr0", rd_addr_0, 0);
      goto_cycle(base + 4);
      chk("lit_wr_first_en", wr_en, 1);
      chk("lit_wr_first_a1", wr_addr_1, 1);
      goto_cycle(base + 10);
      $display("txn: extra start during busy at cycle %0d", cyc);
      chk("lit_s2b2_addr1", rd_addr_1, 6);
      chk("lit_s2b2_bank", bank, 1);
      pulse_start();
      chk("lit_s2b3_addr2", rd_addr_2, 7);
      chk("lit_s2b3_w", w_addr, 2);
      goto_cycle(base + 16);
      chk("lit_s3b1_addr1", rd_addr_1, 5);
      chk("lit_s3b1_addr2", rd_addr_2, 7);
      chk("lit_s3b1_w", w_addr, 1);
      chk("lit_s3b1_bank", bank, 0);
      goto_cycle(base + 22);
      chk("lit_done", done, 1);
      chk("lit_done_bank", bank, 1);
      goto_cycle(base + 23);

      // Run C: back-to-back start right after FIN
      $display("txn: back-to-back start run C at cycle %0d", cyc);
      pulse_start();
      chk("lit_c_issue", rd_en_12, 1);
      chk("lit_c_bank", bank, 0);
      goto_cycle(base + 23 + 22);
      chk("lit_c_done", done, 1);
      goto_cycle(base + 23 + 24);
      chk("lit_c_idle", busy, 0);
      $display("txn: run C complete at cycle %0d", cyc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
